// File: rtl/ipdc_pkg.sv
// Shared op codes, FSM state type and width helper for the image display
// window controller.
package ipdc_pkg;

    localparam logic [3:0] OP_LOAD      = 4'd0;
    localparam logic [3:0] OP_RIGHT     = 4'd1;
    localparam logic [3:0] OP_LEFT      = 4'd2;
    localparam logic [3:0] OP_UP        = 4'd3;
    localparam logic [3:0] OP_DOWN      = 4'd4;
    localparam logic [3:0] OP_SDOWN     = 4'd5;
    localparam logic [3:0] OP_SUP       = 4'd6;
    localparam logic [3:0] OP_SHOW      = 4'd7;
    localparam logic [3:0] OP_MAX_LEGAL = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_OUT
    } state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ipdc_img_buf.sv
// Single-port image buffer with write enable and registered read; the
// boundary where an SRAM macro can be dropped in later.
module ipdc_img_buf #(
    parameter int unsigned AW = 8,
    parameter int unsigned PW = 24
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [PW-1:0] i_wdata,
    output logic [PW-1:0] o_rdata
);

    logic [PW-1:0] mem [2**AW];
    logic [PW-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end else begin
            rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/ipdc_win_ctrl.sv
// Image display controller: loads an IMG_W x IMG_H image, moves/resizes a
// square window on op commands and streams the window out in raster order.
module ipdc_win_ctrl
    import ipdc_pkg::*;
#(
    parameter  int unsigned CH_W    = 8,
    parameter  int unsigned CH_N    = 3,
    parameter  int unsigned IMG_W   = 16,
    parameter  int unsigned IMG_H   = 16,
    parameter  int unsigned WIN_MAX = 4,
    localparam int unsigned PW      = CH_N * CH_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_op_valid,
    input  logic [3:0]    i_op_mode,
    output logic          o_op_ready,
    input  logic          i_in_valid,
    input  logic [PW-1:0] i_in_data,
    output logic          o_in_ready,
    output logic          o_out_valid,
    output logic [PW-1:0] o_out_data
);

    localparam int unsigned XW   = cnt_w(IMG_W);
    localparam int unsigned YW   = cnt_w(IMG_H);
    localparam int unsigned SW   = cnt_w(WIN_MAX) + 1;
    localparam int unsigned CW   = SW - 1;
    localparam int unsigned AW   = XW + YW;
    localparam int unsigned XB   = XW + 2;
    localparam int unsigned YB   = YW + 2;
    localparam int unsigned NPIX = IMG_W * IMG_H;

    localparam logic [SW-1:0] S_MAX  = SW'(WIN_MAX);
    localparam logic [XB-1:0] W_LIM  = XB'(IMG_W);
    localparam logic [YB-1:0] H_LIM  = YB'(IMG_H);
    localparam logic [AW-1:0] LD_END = AW'(NPIX - 1);

    state_e        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [SW-1:0] s_q, s_d;
    logic          loaded_q, loaded_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          op_ready_q, op_ready_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic          wr_en;
    logic          op_acc;
    logic [AW-1:0] buf_addr;
    logic [PW-1:0] buf_rdata;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
    logic [SW-1:0] s_m1;
    logic [SW:0]   s2;
    logic          last_col;

    assign wr_en    = in_ready_q & i_in_valid;
    assign op_acc   = op_ready_q & i_op_valid;
    assign scan_x   = ox_q + XW'(col_q);
    assign scan_y   = oy_q + YW'(row_q);
    assign buf_addr = in_ready_q ? ld_cnt_q : {scan_y, scan_x};
    assign s_m1     = s_q - SW'(1);
    assign s2       = {s_q, 1'b0};
    assign last_col = (col_q == s_m1[CW-1:0]);

    ipdc_img_buf #(
        .AW (AW),
        .PW (PW)
    ) u_img_buf (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_addr  (buf_addr),
        .i_wdata (i_in_data),
        .o_rdata (buf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        s_d         = s_q;
        loaded_d    = loaded_q;
        ld_cnt_d    = ld_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = (state_q == ST_OUT);

        case (state_q)
            ST_IDLE: begin
                if (op_acc) begin
                    op_d = i_op_mode;
                    if (i_op_mode == OP_LOAD) begin
                        state_d  = ST_LOAD;
                        ld_cnt_d = '0;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_LOAD: begin
                if (wr_en) begin
                    ld_cnt_d = ld_cnt_q + AW'(1);
                    if (ld_cnt_q == LD_END) begin
                        loaded_d = 1'b1;
                        ox_d     = '0;
                        oy_d     = '0;
                        s_d      = S_MAX;
                        row_d    = '0;
                        col_d    = '0;
                        state_d  = ST_OUT;
                    end
                end
            end
            ST_CALC: begin
                state_d = ST_IDLE;
                if ((op_q <= OP_MAX_LEGAL) && loaded_q) begin
                    state_d = ST_OUT;
                    row_d   = '0;
                    col_d   = '0;
                    // Bounds are evaluated at widened precision so ox+S etc. cannot wrap.
                    case (op_q)
                        OP_RIGHT: if ((XB'(ox_q) + XB'(s_q)) < W_LIM) ox_d = ox_q + XW'(1);
                        OP_LEFT:  if (ox_q != '0) ox_d = ox_q - XW'(1);
                        OP_UP:    if (oy_q != '0) oy_d = oy_q - YW'(1);
                        OP_DOWN:  if ((YB'(oy_q) + YB'(s_q)) < H_LIM) oy_d = oy_q + YW'(1);
                        OP_SDOWN: if (s_q > SW'(2)) s_d = s_q >> 1;
                        OP_SUP: begin
                            if ((s2 <= (SW + 1)'(WIN_MAX)) &&
                                ((XB'(ox_q) + XB'(s2)) <= W_LIM) &&
                                ((YB'(oy_q) + YB'(s2)) <= H_LIM)) begin
                                s_d = s2[SW-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_OUT: begin
                if (last_col) begin
                    col_d = '0;
                    row_d = row_q + CW'(1);
                    if (row_q == s_m1[CW-1:0]) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready waits one extra cycle after OUT so it rises after the last pixel leaves.
        op_ready_d = (state_d == ST_IDLE) && (state_q != ST_OUT);
        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            s_q         <= S_MAX;
            loaded_q    <= 1'b0;
            ld_cnt_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            op_ready_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            s_q         <= s_d;
            loaded_q    <= loaded_d;
            ld_cnt_q    <= ld_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            op_ready_q  <= op_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_op_ready  = op_ready_q;
    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_valid_q ? buf_rdata : '0;

endmodule

// File: tb/tb_ipdc_win_ctrl.sv
// Self-checking bench for ipdc_win_ctrl against a window/image reference model.
module tb_ipdc_win_ctrl;

    localparam int IMG_W   = 16;
    localparam int IMG_H   = 16;
    localparam int WIN_MAX = 4;
    localparam int PW      = 24;
    localparam int NPIX    = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic [3:0]    op_mode = '0;
    logic          op_ready;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_data;

    always #5 clk = ~clk;

    ipdc_win_ctrl #(
        .CH_W    (8),
        .CH_N    (3),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .WIN_MAX (WIN_MAX)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_op_valid  (op_valid),
        .i_op_mode   (op_mode),
        .o_op_ready  (op_ready),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data)
    );

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] img [NPIX];
    int            m_ox, m_oy, m_s;
    bit            m_loaded;
    logic [PW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_window();
        for (int r = 0; r < m_s; r++)
            for (int c = 0; c < m_s; c++)
                exp_q.push_back(img[(m_oy + r) * IMG_W + m_ox + c]);
    endfunction

    function automatic void model_reset();
        m_ox = 0;
        m_oy = 0;
        m_s = WIN_MAX;
        m_loaded = 1'b0;
    endfunction

    function automatic void model_op(input int code);
        if (code > 7 || code == 0 || !m_loaded) return;
        case (code)
            1: if (m_ox + m_s < IMG_W) m_ox++;
            2: if (m_ox > 0) m_ox--;
            3: if (m_oy > 0) m_oy--;
            4: if (m_oy + m_s < IMG_H) m_oy++;
            5: if (m_s > 2) m_s = m_s / 2;
            6: if (2 * m_s <= WIN_MAX && m_ox + 2 * m_s <= IMG_W && m_oy + 2 * m_s <= IMG_H) m_s = 2 * m_s;
            default: ;
        endcase
        push_window();
    endfunction

    task automatic issue_op(input string tag, input logic [3:0] code);
        int n;
        n = 0;
        while (!op_ready && n < 50) begin
            step();
            n++;
        end
        if (!op_ready) chk({tag, "_ready_timeout"}, op_ready, 1);
        op_valid = 1'b1;
        op_mode  = code;
        step();
        op_valid = 1'b0;
        op_mode  = 4'($urandom);
        chk({tag, "_ready_drop"}, op_ready, 0);
    endtask

    // Consume the output burst until o_op_ready returns, comparing each pixel.
    task automatic collect(input string tag, input int max_cycles, output int waited);
        int  got, first, last, n_exp;
        bit  prev_v, done;
        got = 0; first = -1; last = -1; prev_v = 0; done = 0; waited = max_cycles;
        n_exp = exp_q.size();
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) chk({tag, "_pix"}, out_data, exp_q.pop_front());
                else chk({tag, "_extra_pix"}, got + 1, n_exp);
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end else begin
                chk({tag, "_idle_data"}, out_data, 0);
            end
            if (op_ready) begin
                if (n_exp > 0) chk({tag, "_ready_after_last"}, prev_v, 1);
                waited = cyc;
                done = 1;
                break;
            end
            prev_v = out_valid;
            step();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_count"}, got, n_exp);
        if (got > 0) chk({tag, "_contig"}, last - first + 1, got);
        exp_q.delete();
    endtask

    task automatic do_op(input string tag, input logic [3:0] code);
        int waited, n_exp;
        model_op(code);
        n_exp = exp_q.size();
        issue_op(tag, code);
        collect(tag, 40, waited);
        if (n_exp == 0) chk({tag, "_ready_within2"}, (waited <= 2), 1);
    endtask

    // gap_mode: 0 none, 1 every 3rd cycle idle, 2 random; random_pix picks image content.
    task automatic do_load(input string tag, input int gap_mode, input bit random_pix);
        int idx, k, waited;
        bit rdy, v;
        for (int i = 0; i < NPIX; i++)
            img[i] = random_pix ? PW'($urandom) : {3{8'(i)}};
        issue_op(tag, 4'd0);
        chk({tag, "_in_ready"}, in_ready, 1);
        idx = 0;
        k = 0;
        while (idx < NPIX && k < 3000) begin
            case (gap_mode)
                1: v = (k % 3) != 2;
                2: v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            in_valid = v;
            in_data  = v ? img[idx] : PW'($urandom);
            rdy = in_ready;
            step();
            if (v && rdy) idx++;
            k++;
        end
        in_valid = 1'b0;
        chk({tag, "_all_written"}, idx, NPIX);
        chk({tag, "_in_ready_drop"}, in_ready, 0);
        m_loaded = 1'b1;
        m_ox = 0;
        m_oy = 0;
        m_s = WIN_MAX;
        push_window();
        collect(tag, 40, waited);
    endtask

    initial begin
        int code, n, want;
        logic [PW-1:0] exp_pix;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_ready", op_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", op_ready, 1);

        do_op("illegal_f", 4'hF);
        do_op("up_unloaded", 4'd3);

        do_load("load_plain", 0, 1'b0);
        do_load("load_gaps", 1, 1'b0);

        for (int i = 0; i < 13; i++) do_op("right_sat", 4'd1);
        chk("model_ox_sat", m_ox, 12);

        do_op("scale_down", 4'd5);
        do_op("right_a", 4'd1);
        do_op("right_b", 4'd1);
        do_op("scale_up_refused", 4'd6);

        do_load("load_rand", 2, 1'b1);
        for (int i = 0; i < 40; i++) begin
            code = $urandom_range(1, 15);
            do_op("rand_op", 4'(code));
        end

        // Reset in the middle of the 8th output pixel of a redisplay.
        do_load("load_pre_rst", 0, 1'b0);
        model_op(7);
        issue_op("rst_mid", 4'd7);
        n = 0;
        want = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                exp_pix = exp_q.pop_front();
                chk("rst_mid_pix", out_data, exp_pix);
                n++;
                if (n == 8) begin
                    rst_n = 1'b0;
                    #1;
                    want = 1;
                    chk("rst_mid_valid", out_valid, 0);
                    chk("rst_mid_data", out_data, 0);
                    chk("rst_mid_op_ready", op_ready, 0);
                    break;
                end
            end
            step();
        end
        chk("rst_mid_reached", want, 1);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst_mid", op_ready, 1);
        do_op("show_unloaded", 4'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
